// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, widths and the
// baud divider helper used by both RX and TX.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int UART_DATA_W     = 8;
  localparam int UART_OVERSAMPLE = 16;

  function automatic int baud_div(
    input int clk_freq,
    input int baud,
    input int os
  );
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Receive-side bundle: serial line in, byte and strobes out.
// master = receiver, slave = consumer / line driver.
interface uart_rx_os16_if;
  import uart_pkg::*;

  logic                   rx;
  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_busy;
  logic                   rx_done;
  logic                   rx_frame_err;

  modport master (
    input  rx,
    output rx_data,
    output rx_busy,
    output rx_done,
    output rx_frame_err
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_busy,
    input  rx_done,
    input  rx_frame_err
  );

endinterface

// File: rtl/uart_rx_os16_baud_tick_gen.sv
// Oversample tick divider: one tick every DIV clocks while
// enabled, counter parked at zero otherwise.
module baud_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver, 16x oversampled, centre sampling,
// start-bit glitch reject and stop-bit framing check.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_os16_if.master bus
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);

  logic rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_e state_q, state_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [2:0] bit_q, bit_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic tick, fall, run, stop_pt;

  assign fall = rx_prev_q & ~rx_sync_q;
  assign run  = (state_q != IDLE);

  baud_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (run),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      samp_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      samp_q    <= samp_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          samp_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (samp_q == MID) begin
            state_d = rx_sync_q ? IDLE : DATA;
            samp_d  = '0;
          end else begin
            samp_d = samp_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (samp_q == LAST) begin
            shift_d = {rx_sync_q, shift_q[UART_DATA_W-1:1]};
            samp_d  = '0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = STOP;
            end
          end else begin
            samp_d = samp_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (samp_q == LAST) begin
            state_d = IDLE;
            samp_d  = '0;
          end else begin
            samp_d = samp_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stop midpoint decides between a good byte and a framing error.
  always_comb begin
    stop_pt = (state_q == STOP) && tick && (samp_q == LAST);
    done_d  = stop_pt && rx_sync_q;
    err_d   = stop_pt && !rx_sync_q;
    data_d  = done_d ? shift_q : data_q;
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_busy      = run;
  assign bus.rx_done      = done_q;
  assign bus.rx_frame_err = err_q;

endmodule
